// File: rtl/skid_buffer_16_if.sv
// Valid/ready stream bundle for skid_buffer_16.
//
// Handshake: a word transfers on a rising clock edge where both valid and
// ready are 1. A producer holding valid=1 keeps its data steady until the
// transfer. Ready may depend only on registered state, never on valid.
// The s_* group is the upstream side and the m_* group is the downstream side.
interface skid_buffer_16_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  // The stage itself: sinks the upstream stream and sources the downstream one.
  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready,
    output m_data,
    output m_valid,
    input  m_ready
  );

  // The surrounding producer and consumer.
  modport master (
    output s_data,
    output s_valid,
    input  s_ready,
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/skid_buffer_16.sv
// Two-entry skid buffer terminating a 16-bit valid/ready stream.
// The main register drives m_data and the skid register catches the one
// extra word that arrives while the consumer is stalled. Every output,
// including s_ready, is a decode of registered state. This means no
// combinational path runs from m_ready to s_ready.
module skid_buffer_16 #(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  skid_buffer_16_if.slave     bus,
  output logic [1:0]          level,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;

  logic w_in_fire;
  logic w_out_fire;
  logic w_main_from_in;
  logic w_main_from_skid;
  logic w_skid_from_in;

  // Handshake qualifiers derived from the registered state.
  assign w_in_fire  = bus.s_valid & (r_state != ST_FULL);
  assign w_out_fire = bus.m_ready & (r_state != ST_EMPTY);

  // Next-state and data-load decisions. Flush overrides both handshakes.
  always_comb begin
    w_next_state     = r_state;
    w_main_from_in   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_in   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_main_from_in = 1'b1;
          w_next_state   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_in_fire && !w_out_fire) begin
          w_skid_from_in = 1'b1;
          w_next_state   = ST_FULL;
        end else if (!w_in_fire && w_out_fire) begin
          w_next_state   = ST_EMPTY;
        end else if (w_in_fire && w_out_fire) begin
          w_main_from_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (w_out_fire) begin
          w_main_from_skid = 1'b1;
          w_next_state     = ST_BUSY;
        end
      end
      default: begin
        w_next_state = ST_EMPTY;
      end
    endcase
    if (flush) begin
      w_next_state     = ST_EMPTY;
      w_main_from_in   = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_from_in   = 1'b0;
    end
  end

  // State register. The state returns to EMPTY asynchronously on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Data registers. They change only when a word is loaded, so a flush leaves them intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_main_from_in) begin
        r_main <= bus.s_data;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_from_in) begin
        r_skid <= bus.s_data;
      end
    end
  end

  // Output decode from registers only.
  always_comb begin
    bus.m_data  = r_main;
    bus.m_valid = (r_state != ST_EMPTY);
    bus.s_ready = (r_state != ST_FULL);
    o_dbg_state = r_state;
    case (r_state)
      ST_BUSY: level = 2'd1;
      ST_FULL: level = 2'd2;
      default: level = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_skid_buffer_16.sv
// Bench for skid_buffer_16: directed scenarios with literal expectations,
// then a long random run compared every cycle against a queue model.
module tb_skid_buffer_16;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [1:0] level;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  skid_buffer_16_if #(.WIDTH(W)) bus ();

  skid_buffer_16 #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus),
    .level       (level),
    .o_dbg_state (dbg_state)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The stage is modelled as a FIFO of at most two words.
  // exp_main is the last word that reached the head, which is what m_data shows.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_main = '0;
  int           n_out = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_main = '0;
    end else begin
      logic m_fire, i_fire;
      m_fire = (exp_q.size() > 0) && bus.m_ready;
      i_fire = bus.s_valid && (exp_q.size() < 2);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_fire) begin
          void'(exp_q.pop_front());
          n_out++;
        end
        if (i_fire) exp_q.push_back(bus.s_data);
      end
      if (exp_q.size() > 0) exp_main = exp_q[0];
    end
  end

  // ---------------- compare process ----------------
  logic         prev_valid = 1'b0;
  logic [W-1:0] prev_data  = '0;

  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      chk("model_m_valid", {31'd0, bus.m_valid}, {31'd0, exp_q.size() > 0});
      chk("model_s_ready", {31'd0, bus.s_ready}, {31'd0, exp_q.size() < 2});
      chk("model_level",   {30'd0, level},       exp_q.size());
      chk("model_m_data",  {16'd0, bus.m_data},  {16'd0, exp_main});
      if (prev_valid && !bus.m_ready && !flush) begin
        chk("stable_m_valid", {31'd0, bus.m_valid}, 32'd1);
        chk("stable_m_data",  {16'd0, bus.m_data},  {16'd0, prev_data});
      end
      prev_valid = bus.m_valid;
      prev_data  = bus.m_data;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bus.s_valid = v;
    bus.s_data  = d;
    bus.m_ready = r;
    flush       = f;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int start_out;
    int cycles;
    rst_n = 1'b0;
    drive(1'b1, 16'hFFFF, 1'b0, 1'b0);
    repeat (2) step();
    chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_level",   {30'd0, level},       32'd0);
    chk("rst_s_ready", {31'd0, bus.s_ready}, 32'd1);
    chk("rst_m_data",  {16'd0, bus.m_data},  32'd0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // Streaming: one word per cycle with a latency of one cycle.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b0);
      step();
      chk("stream_data",    {16'd0, bus.m_data},  i);
      chk("stream_s_ready", {31'd0, bus.s_ready}, 32'd1);
      chk("stream_level",   {30'd0, level},       32'd1);
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    step();
    chk("stream_drain", {31'd0, bus.m_valid}, 32'd0);

    // Backpressure: the third word is refused while the stage is full.
    drive(1'b1, 16'hAAAA, 1'b0, 1'b0); step();
    drive(1'b1, 16'hBBBB, 1'b0, 1'b0); step();
    chk("bp_level2", {30'd0, level}, 32'd2);
    drive(1'b1, 16'hCCCC, 1'b0, 1'b0); step();
    chk("bp_level_hold", {30'd0, level},       32'd2);
    chk("bp_s_ready",    {31'd0, bus.s_ready}, 32'd0);
    chk("bp_head",       {16'd0, bus.m_data},  32'hAAAA);
    drive(1'b1, 16'hCCCC, 1'b1, 1'b0); step();
    chk("bp_out1", {16'd0, bus.m_data}, 32'hBBBB);
    step();
    chk("bp_out2", {16'd0, bus.m_data}, 32'hCCCC);
    drive(1'b0, 16'h0, 1'b1, 1'b0); step();
    chk("bp_empty", {30'd0, level}, 32'd0);

    // Simultaneous accept and consume while one word is held.
    drive(1'b1, 16'h1234, 1'b0, 1'b0); step();
    chk("sim_level1", {30'd0, level}, 32'd1);
    drive(1'b1, 16'h5678, 1'b1, 1'b0); step();
    chk("sim_data",  {16'd0, bus.m_data}, 32'h5678);
    chk("sim_level", {30'd0, level},      32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b0); step();

    // Flush while full. The concurrent input and output are both discarded.
    drive(1'b1, 16'h1111, 1'b0, 1'b0); step();
    drive(1'b1, 16'h2222, 1'b0, 1'b0); step();
    drive(1'b1, 16'hDEAD, 1'b1, 1'b1); step();
    chk("flush_level",   {30'd0, level},       32'd0);
    chk("flush_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("flush_keep",    {16'd0, bus.m_data},  32'h1111);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    repeat (3) step();
    chk("flush_no_dead", {31'd0, bus.m_valid}, 32'd0);

    // Asynchronous reset mid-stream while full.
    drive(1'b1, 16'h3333, 1'b0, 1'b0); step();
    drive(1'b1, 16'h4444, 1'b0, 1'b0); step();
    chk("arst_pre_level", {30'd0, level}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("arst_level",   {30'd0, level},       32'd0);
    chk("arst_m_data",  {16'd0, bus.m_data},  32'd0);
    chk("arst_s_ready", {31'd0, bus.s_ready}, 32'd1);
    drive(1'b1, 16'h5555, 1'b1, 1'b0);
    step();
    chk("arst_no_store", {30'd0, level}, 32'd0);
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // Random traffic. The compare process checks every cycle.
    start_out = n_out;
    cycles    = 0;
    while ((n_out - start_out) < 10000 && cycles < 60000) begin
      drive(($urandom_range(0, 9) < 7), W'($urandom()), ($urandom_range(0, 9) < 7), 1'b0);
      step();
      cycles++;
    end
    chk("random_words_out", {31'd0, (n_out - start_out) >= 10000}, 32'd1);

    drive(1'b0, 16'h0, 1'b1, 1'b0);
    repeat (4) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
